// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one bus access per instruction over a req/ack bus,
// with stall generation, alignment/funct3 fault detection, timeout and load formatting.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_M,
    input  logic        rd_en_M,
    input  logic [31:0] alu_out_M,
    input  logic [31:0] rdata2_M,
    input  logic [31:0] inst_M,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data_M,
    output logic        stall_M,
    output logic        access_fault_M,
    output logic        bus_err_M
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] timer;
    logic [2:0]  f3, ld_f3;
    logic [1:0]  ld_off;
    logic        access, f3_ok, aligned, legal;
    logic        launch, ack_hit, timeout;
    logic [31:0] wdata_nxt, fmt;
    logic [3:0]  be_nxt;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        unused_inst;

    assign f3          = inst_M[14:12];
    assign access      = wr_en_M | rd_en_M;
    assign unused_inst = ^{inst_M[31:15], inst_M[11:0]};

    // Stores only allow 000..010; loads additionally allow the unsigned forms 100/101.
    always_comb begin
        f3_ok = 1'b0;
        case (f3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~wr_en_M;
            default:                f3_ok = 1'b0;
        endcase
        case (f3[1:0])
            2'b01:   aligned = ~alu_out_M[0];
            2'b10:   aligned = (alu_out_M[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        legal = f3_ok & aligned;
    end

    always_comb begin
        case (f3[1:0])
            2'b00: begin
                wdata_nxt = {4{rdata2_M[7:0]}};
                be_nxt    = 4'b0001 << alu_out_M[1:0];
            end
            2'b01: begin
                wdata_nxt = {2{rdata2_M[15:0]}};
                be_nxt    = alu_out_M[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_nxt = rdata2_M;
                be_nxt    = 4'b1111;
            end
        endcase
    end

    // Lane offset and funct3 are captured at launch so formatting never depends on M inputs.
    always_comb begin
        byte_sel = mem_rdata[{ld_off, 3'b000} +: 8];
        half_sel = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ld_f3)
            3'b000:  fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  fmt = {{16{half_sel[15]}}, half_sel};
            3'b100:  fmt = {24'h0, byte_sel};
            3'b101:  fmt = {16'h0, half_sel};
            default: fmt = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        stall_M        = 1'b0;
        access_fault_M = 1'b0;
        launch         = 1'b0;
        ack_hit        = 1'b0;
        timeout        = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (!legal) begin
                        access_fault_M = 1'b1;
                    end else begin
                        launch    = 1'b1;
                        stall_M   = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_M = 1'b1;
                if (mem_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = DONE;
                end else if (timer == TIMER_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            load_data_M <= '0;
            bus_err_M   <= 1'b0;
            timer       <= '0;
            ld_f3       <= '0;
            ld_off      <= '0;
        end else begin
            bus_err_M <= 1'b0;
            if (launch) begin
                mem_req   <= 1'b1;
                mem_we    <= wr_en_M;
                mem_addr  <= {alu_out_M[31:2], 2'b00};
                mem_wdata <= wdata_nxt;
                mem_be    <= wr_en_M ? be_nxt : 4'b1111;
                ld_f3     <= f3;
                ld_off    <= alu_out_M[1:0];
                timer     <= '0;
            end
            if (state == BUSY) begin
                timer <= timer + 16'd1;
                if (ack_hit) begin
                    mem_req <= 1'b0;
                    if (!mem_we) load_data_M <= fmt;
                end else if (timeout) begin
                    mem_req     <= 1'b0;
                    bus_err_M   <= 1'b1;
                    load_data_M <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: stimulus queues expected bus requests and
// completions; a negedge monitor checks them as mem_req rises and falls.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en_M = 1'b0, rd_en_M = 1'b0;
    logic [31:0] alu_out_M = '0, rdata2_M = '0, inst_M = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] load_data_M;
    logic        stall_M, access_fault_M, bus_err_M;

    lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .wr_en_M(wr_en_M), .rd_en_M(rd_en_M),
        .alu_out_M(alu_out_M), .rdata2_M(rdata2_M), .inst_M(inst_M),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .load_data_M(load_data_M), .stall_M(stall_M), .access_fault_M(access_fault_M),
        .bus_err_M(bus_err_M)
    );

    always #5 clk = ~clk;

    typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} req_t;
    typedef struct {logic [31:0] data; logic err;} cmp_t;

    req_t        req_q[$];
    cmp_t        cmp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ld = '0;
    logic        prev_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            prev_req = 1'b0;
        end else begin
            if (mem_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected request", 32'd1, 32'd0);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("req we", {31'h0, mem_we}, {31'h0, r.we});
                    chk("req addr", mem_addr, r.addr);
                    chk("req be", {28'h0, mem_be}, {28'h0, r.be});
                    if (r.we) chk("req wdata", mem_wdata, r.wdata);
                end
            end
            if (!mem_req && prev_req) begin
                if (cmp_q.size() == 0) begin
                    chk("unexpected completion", 32'd1, 32'd0);
                end else begin
                    cmp_t c;
                    c = cmp_q.pop_front();
                    chk("load_data", load_data_M, c.data);
                    chk("bus_err", {31'h0, bus_err_M}, {31'h0, c.err});
                end
            end else if (bus_err_M) begin
                chk("stray bus_err", 32'd1, 32'd0);
            end
            prev_req = mem_req;
        end
    end

    task automatic drive(input logic we, input logic rd, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        wr_en_M   = we;
        rd_en_M   = rd;
        inst_M    = {17'h0, f3, 5'h0, 7'h03};
        alu_out_M = a;
        rdata2_M  = d;
    endtask

    // ack_at = BUSY cycle (1-based) in which mem_ack is presented; -1 = never.
    task automatic run(input string name, input logic we, input logic rd, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input int ack_at,
                       input logic [31:0] rdata, input int exp_stall);
        int n;
        n = 0;
        @(posedge clk); #1;
        drive(we, rd, f3, a, d);
        mem_rdata = rdata;
        forever begin
            @(negedge clk);
            if (!stall_M || n > 40) break;
            mem_ack = (n == ack_at);
            n++;
        end
        mem_ack = 1'b0;
        wr_en_M = 1'b0;
        rd_en_M = 1'b0;
        chk({name, " stall cycles"}, 32'(n), 32'(exp_stall));
    endtask

    task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] data, input logic err);
        req_q.push_back('{we, addr, wdata, be});
        cmp_q.push_back('{data, err});
        exp_ld = data;
    endtask

    task automatic fault(input string name, input logic we, input logic rd,
                         input logic [2:0] f3, input logic [31:0] a);
        @(posedge clk); #1;
        drive(we, rd, f3, a, 32'hFFFF_FFFF);
        @(negedge clk);
        chk({name, " fault"}, {31'h0, access_fault_M}, 32'd1);
        chk({name, " stall"}, {31'h0, stall_M}, 32'd0);
        @(negedge clk);
        chk({name, " no req"}, {31'h0, mem_req}, 32'd0);
        chk({name, " ld held"}, load_data_M, exp_ld);
        wr_en_M = 1'b0;
        rd_en_M = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst mem_req", {31'h0, mem_req}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_be", {28'h0, mem_be}, 32'd0);
        chk("rst load_data", load_data_M, 32'd0);
        chk("rst bus_err", {31'h0, bus_err_M}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        push(1'b0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
        run("LW 100", 1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 4);
        push(1'b1, 32'h200, 32'h78787878, 4'b1000, exp_ld, 1'b0);
        run("SB 203", 1'b1, 1'b0, 3'b000, 32'h203, 32'h12345678, 1, 32'h0, 2);
        push(1'b0, 32'h0, 32'h0, 4'hF, 32'hFFFFFF80, 1'b0);
        run("LB 1", 1'b0, 1'b1, 3'b000, 32'h1, 32'h0, 1, 32'h0000_8000, 2);
        push(1'b0, 32'h0, 32'h0, 4'hF, 32'h0000ABCD, 1'b0);
        run("LHU 2", 1'b0, 1'b1, 3'b101, 32'h2, 32'h0, 2, 32'hABCD_0000, 3);
        push(1'b1, 32'h8, 32'hF00DF00D, 4'b1100, exp_ld, 1'b0);
        run("SH A", 1'b1, 1'b0, 3'b001, 32'hA, 32'hCAFEF00D, 1, 32'h0, 2);
        push(1'b0, 32'h4, 32'h0, 4'hF, 32'hFFFF8001, 1'b0);
        run("LH 6", 1'b0, 1'b1, 3'b001, 32'h6, 32'h0, 1, 32'h8001_0000, 2);
        push(1'b1, 32'h10, 32'h11223344, 4'hF, exp_ld, 1'b0);
        run("SW+rd 10", 1'b1, 1'b1, 3'b010, 32'h10, 32'h11223344, 2, 32'h0, 3);
        push(1'b0, 32'h0, 32'h0, 4'hF, 32'h000000F2, 1'b0);
        run("LBU 3", 1'b0, 1'b1, 3'b100, 32'h3, 32'h0, 1, 32'hF200_0000, 2);

        fault("LW 102", 1'b0, 1'b1, 3'b010, 32'h102);
        fault("LD f3=011", 1'b0, 1'b1, 3'b011, 32'h0);
        fault("SH 1", 1'b1, 1'b0, 3'b001, 32'h1);
        fault("ST f3=100", 1'b1, 1'b0, 3'b100, 32'h0);

        push(1'b0, 32'h40, 32'h0, 4'hF, 32'h0, 1'b1);
        run("LW timeout", 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, -1, 32'h1234_5678, 5);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late ack no req", {31'h0, mem_req}, 32'd0);
        chk("late ack ld", load_data_M, 32'd0);
        chk("bus_err single", {31'h0, bus_err_M}, 32'd0);

        req_q.push_back('{1'b0, 32'h80, 32'h0, 4'hF});
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'b010, 32'h80, 32'h0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("async rst drops req", {31'h0, mem_req}, 32'd0);
        wr_en_M = 1'b0;
        rd_en_M = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("post rst no req", {31'h0, mem_req}, 32'd0);
        chk("post rst ld", load_data_M, 32'd0);
        exp_ld = '0;

        push(1'b0, 32'h300, 32'h0, 4'hF, 32'h55AA55AA, 1'b0);
        run("LW 300", 1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 2, 32'h55AA55AA, 3);

        repeat (3) @(negedge clk);
        chk("req queue empty", 32'(req_q.size()), 32'd0);
        chk("cmp queue empty", 32'(cmp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
